// File: rtl/arm_lp_pkg.sv
// arm_lp_pkg: shared widths and control encodings for the operand-preparation slice.
package arm_lp_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int OFFSET_W = 16;
  localparam int ZERO_REG = 31;
  typedef enum logic {EXT_ZERO = 1'b0, EXT_SIGN = 1'b1} ext_mode_e;
  typedef enum logic {ALU_SRC_REG = 1'b0, ALU_SRC_IMM = 1'b1} alu_src_e;
endpackage

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W storage with one write port and two raw read ports.
module register_file #(
  parameter int DATA_W   = arm_lp_pkg::DATA_W,
  parameter int ADDR_W   = arm_lp_pkg::ADDR_W,
  parameter int ZERO_REG = arm_lp_pkg::ZERO_REG
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  logic [DATA_W-1:0] regs_q [2**ADDR_W];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != ZR) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];
endmodule

// File: rtl/operand_stage.sv
// operand_stage: register read with write bypass, operand-2 select and offset extension,
// registered into a one-entry valid/ready buffer that absorbs write-backs while stalled.
module operand_stage #(
  parameter int DATA_W   = arm_lp_pkg::DATA_W,
  parameter int ADDR_W   = arm_lp_pkg::ADDR_W,
  parameter int OFFSET_W = arm_lp_pkg::OFFSET_W,
  parameter int ZERO_REG = arm_lp_pkg::ZERO_REG
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   reg1,
  input  logic [ADDR_W-1:0]   reg2,
  input  logic [ADDR_W-1:0]   destReg,
  input  logic                aluSRC,
  input  logic                extMode,
  input  logic [OFFSET_W-1:0] pcOffsetOrig,
  input  logic                regWrite,
  input  logic [ADDR_W-1:0]   writeRegister,
  input  logic [DATA_W-1:0]   writeData,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   readData1,
  output logic [DATA_W-1:0]   readData2,
  output logic [DATA_W-1:0]   storeData,
  output logic [DATA_W-1:0]   pcOffsetFilled,
  output logic [ADDR_W-1:0]   destOut
);
  import arm_lp_pkg::*;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  logic [DATA_W-1:0] raw1, raw2, rd1, rd2, ext, op2;
  logic wr_en, accept, stall, fwd1, fwd2;
  logic valid_q, valid_d, src_q, src_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, sd_q, sd_d, off_q, off_d;
  logic [ADDR_W-1:0] dst_q, dst_d, i1_q, i1_d, i2_q, i2_d;
  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rf (
    .clock(clock), .reset_n(reset_n), .we_i(wr_en), .waddr_i(writeRegister), .wdata_i(writeData),
    .raddr1_i(reg1), .raddr2_i(reg2), .rdata1_o(raw1), .rdata2_o(raw2)
  );
  assign wr_en = regWrite && writeRegister != ZR;
  assign rd1 = reg1 == ZR ? '0 : wr_en && writeRegister == reg1 ? writeData : raw1;
  assign rd2 = reg2 == ZR ? '0 : wr_en && writeRegister == reg2 ? writeData : raw2;
  assign ext = {{(DATA_W-OFFSET_W){extMode == EXT_SIGN && pcOffsetOrig[OFFSET_W-1]}}, pcOffsetOrig};
  assign op2 = aluSRC == ALU_SRC_IMM ? ext : rd2;
  assign in_ready = !valid_q || out_ready;
  assign accept = in_valid && in_ready && !flush;
  assign stall = valid_q && !out_ready;
  // A stalled entry keeps tracking write-backs to its sources so it never goes stale.
  assign fwd1 = stall && wr_en && writeRegister == i1_q;
  assign fwd2 = stall && wr_en && writeRegister == i2_q;
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
    rd1_d = accept ? rd1 : fwd1 ? writeData : rd1_q;
    sd_d = accept ? rd2 : fwd2 ? writeData : sd_q;
    rd2_d = accept ? op2 : fwd2 && src_q == ALU_SRC_REG ? writeData : rd2_q;
    off_d = accept ? ext : off_q;
    dst_d = accept ? destReg : dst_q;
    i1_d = accept ? reg1 : i1_q;
    i2_d = accept ? reg2 : i2_q;
    src_d = accept ? aluSRC : src_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      rd1_q <= '0;
      rd2_q <= '0;
      sd_q <= '0;
      off_q <= '0;
      dst_q <= '0;
      i1_q <= '0;
      i2_q <= '0;
      src_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      sd_q <= sd_d;
      off_q <= off_d;
      dst_q <= dst_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
      src_q <= src_d;
    end
  end
  assign out_valid = valid_q;
  assign readData1 = rd1_q;
  assign readData2 = rd2_q;
  assign storeData = sd_q;
  assign pcOffsetFilled = off_q;
  assign destOut = dst_q;
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed scenarios plus random traffic checked against a behavioural model.
module tb_operand_stage;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid, in_ready, aluSRC, extMode, regWrite, flush, out_valid, out_ready;
  logic [4:0] reg1, reg2, destReg, writeRegister, destOut;
  logic [15:0] pcOffsetOrig;
  logic [31:0] writeData, readData1, readData2, storeData, pcOffsetFilled;
  int n_cmp = 0, n_err = 0;
  logic [31:0] rf [32];
  logic m_v, m_src;
  logic [31:0] m_r1, m_r2, m_sd, m_off;
  logic [4:0] m_dst, m_i1, m_i2;

  operand_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .reg1(reg1), .reg2(reg2), .destReg(destReg), .aluSRC(aluSRC), .extMode(extMode),
    .pcOffsetOrig(pcOffsetOrig), .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .readData1(readData1), .readData2(readData2), .storeData(storeData),
    .pcOffsetFilled(pcOffsetFilled), .destOut(destOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd31) return 32'h0;
    if (regWrite && writeRegister == idx) return writeData;
    return rf[idx];
  endfunction

  task automatic model_reset();
    foreach (rf[i]) rf[i] = 32'h0;
    m_v = 0; m_src = 0; m_r1 = 0; m_r2 = 0; m_sd = 0; m_off = 0; m_dst = 0; m_i1 = 0; m_i2 = 0;
  endtask

  task automatic idle();
    in_valid = 0; reg1 = 0; reg2 = 0; destReg = 0; aluSRC = 0; extMode = 0; pcOffsetOrig = 0;
    regWrite = 0; writeRegister = 0; writeData = 0; flush = 0; out_ready = 1;
  endtask

  // One clock: check readiness, advance the model with the current inputs, then check the buffer.
  task automatic cycle();
    logic rdy, acc, stall;
    logic [31:0] a, b, x;
    #1;
    rdy = !m_v || out_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy && !flush;
    a = model_read(reg1);
    b = model_read(reg2);
    x = extMode ? 32'($signed(pcOffsetOrig)) : 32'(pcOffsetOrig);
    stall = m_v && !out_ready;
    @(posedge clock);
    if (acc) begin
      m_r1 = a; m_sd = b; m_r2 = aluSRC ? x : b; m_off = x;
      m_dst = destReg; m_i1 = reg1; m_i2 = reg2; m_src = aluSRC;
    end else if (stall && regWrite && writeRegister != 5'd31) begin
      if (writeRegister == m_i1) m_r1 = writeData;
      if (writeRegister == m_i2) begin
        m_sd = writeData;
        if (!m_src) m_r2 = writeData;
      end
    end
    m_v = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m_v;
    if (regWrite && writeRegister != 5'd31) rf[writeRegister] = writeData;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    if (m_v) begin
      chk("readData1", readData1, m_r1);
      chk("readData2", readData2, m_r2);
      chk("storeData", storeData, m_sd);
      chk("pcOffsetFilled", pcOffsetFilled, m_off);
      chk("destOut", 32'(destOut), 32'(m_dst));
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_readData1", readData1, 32'h0);
    chk("rst_readData2", readData2, 32'h0);
    chk("rst_storeData", storeData, 32'h0);
    chk("rst_pcOffsetFilled", pcOffsetFilled, 32'h0);
    chk("rst_destOut", 32'(destOut), 32'h0);
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clock); #2;
    reset_n = 1;
    // Write X3, then read X3 and the zero register.
    regWrite = 1; writeRegister = 3; writeData = 32'hAA;
    cycle();
    chk("pre_accept_rd1", readData1, 32'h0);
    idle(); in_valid = 1; reg1 = 3; reg2 = 31; destReg = 4;
    cycle();
    chk("x3_rd1", readData1, 32'hAA);
    chk("x31_rd2", readData2, 32'h0);
    // Same-cycle bypass.
    idle(); in_valid = 1; reg1 = 5; regWrite = 1; writeRegister = 5; writeData = 32'h1234_5678;
    cycle();
    chk("bypass_rd1", readData1, 32'h1234_5678);
    // Extension, with X2 holding a known value for storeData.
    idle(); regWrite = 1; writeRegister = 2; writeData = 32'h55;
    cycle();
    idle(); in_valid = 1; reg2 = 2; aluSRC = 1; extMode = 1; pcOffsetOrig = 16'h8001;
    cycle();
    chk("sext_rd2", readData2, 32'hFFFF_8001);
    chk("sext_off", pcOffsetFilled, 32'hFFFF_8001);
    chk("sext_sd", storeData, 32'h55);
    extMode = 0;
    cycle();
    chk("zext_rd2", readData2, 32'h0000_8001);
    chk("zext_sd", storeData, 32'h55);
    // Stall forwarding into held reg2.
    idle(); in_valid = 1; reg1 = 0; reg2 = 7;
    cycle();
    out_ready = 0; regWrite = 1; writeRegister = 7; writeData = 32'hDEAD_BEEF;
    cycle();
    chk("fwd_rd2", readData2, 32'hDEAD_BEEF);
    chk("fwd_sd", storeData, 32'hDEAD_BEEF);
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    regWrite = 0;
    cycle();
    chk("stall_in_ready2", 32'(in_ready), 32'h0);
    // Writes to the zero register never reach a held entry.
    idle(); in_valid = 1; reg1 = 31; reg2 = 31;
    cycle();
    out_ready = 0; in_valid = 0; regWrite = 1; writeRegister = 31; writeData = 32'hFFFF_FFFF;
    cycle();
    chk("x31_nofwd_rd1", readData1, 32'h0);
    chk("x31_nofwd_rd2", readData2, 32'h0);
    // Flush drops the held entry and the incoming one, but the write commits.
    idle(); out_ready = 0; flush = 1; in_valid = 1; reg1 = 1;
    regWrite = 1; writeRegister = 9; writeData = 32'h0000_0099;
    cycle();
    chk("flush_valid", 32'(out_valid), 32'h0);
    idle(); in_valid = 1; reg1 = 9; reg2 = 31;
    cycle();
    chk("flush_write_kept", readData1, 32'h99);
    // Simultaneous consume and accept keeps out_valid high.
    reg1 = 3;
    cycle();
    chk("reload_valid", 32'(out_valid), 32'h1);
    // Reset while stalled clears the entry immediately.
    out_ready = 0; in_valid = 0;
    cycle();
    reset_n = 0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clock); #2;
    reset_n = 1;
    idle(); in_valid = 1; reg1 = 3;
    cycle();
    chk("rf_cleared", readData1, 32'h0);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      reg1 = 5'($urandom_range(0, 31));
      reg2 = $urandom_range(0, 3) == 0 ? 5'd31 : 5'($urandom_range(0, 31));
      destReg = 5'($urandom);
      aluSRC = 1'($urandom);
      extMode = 1'($urandom);
      pcOffsetOrig = 16'($urandom);
      regWrite = 1'($urandom);
      case ($urandom_range(0, 3))
        0: writeRegister = reg1;
        1: writeRegister = reg2;
        2: writeRegister = $urandom_range(0, 1) ? m_i1 : m_i2;
        default: writeRegister = 5'($urandom);
      endcase
      writeData = $urandom;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
